// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with a
// display-stable result register and optional leading-zero blanking.
`timescale 1ns/1ps

module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bcd_converter #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  out_valid
);
    localparam int BW = DIGITS * 4;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] shift;
    logic [BW-1:0]   work, adj, work_nxt;
    logic [CW-1:0]   cnt;
    logic            accept, done;

    // Zero digits with only zeros above them become 4'hF; digit 0 always shows.
    function automatic logic [BW-1:0] fmt(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          lead;
        r    = v;
        lead = 1'b1;
        if (BLANK_LZ) begin
            for (int k = DIGITS - 1; k > 0; k--) begin
                if (lead && v[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hF;
                else                             lead = 1'b0;
            end
        end
        return r;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (.din(work[4*g +: 4]), .dout(adj[4*g +: 4]));
    end

    // Top bit of the adjusted value falls off; unreachable when DIGITS is sized right.
    assign work_nxt = BW'({adj, shift[WIDTH-1]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift     <= '0;
            work      <= '0;
            cnt       <= '0;
            bcd       <= fmt('0);
            out_valid <= 1'b0;
        end else if (accept) begin
            shift     <= bin;
            work      <= '0;
            cnt       <= CW'(WIDTH - 1);
            out_valid <= 1'b0;
        end else if (state == CONV) begin
            shift <= shift << 1;
            work  <= work_nxt;
            if (done) begin
                bcd       <= fmt(work_nxt);
                out_valid <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bcd_converter.sv
// Random and directed checks of bcd_converter (plain and blanked variants)
// against a decimal-digit reference model.
`timescale 1ns/1ps

module tb_bcd_converter;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] bin;
    logic        rdy0, rdy1, ov0, ov1;
    logic [19:0] bcd0, bcd1;
    logic [19:0] prev0, prev1;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_converter #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b0)) dut_plain (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .bin(bin), .bcd(bcd0), .out_valid(ov0));

    bcd_converter #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b1)) dut_blank (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .bin(bin), .bcd(bcd1), .out_valid(ov1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Decimal digits by division, then blank leading zeros above the units digit.
    function automatic logic [19:0] ref_bcd(input int v, input bit blank);
        int          d[5];
        logic [19:0] r;
        bit          lead;
        for (int i = 0; i < 5; i++) begin
            d[i] = v % 10;
            v    = v / 10;
        end
        r    = '0;
        lead = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            if (blank && lead && i > 0 && d[i] == 0) r[i*4 +: 4] = 4'hF;
            else begin
                r[i*4 +: 4] = 4'(d[i]);
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic start(input logic [15:0] v);
        int n = 0;
        while (rdy0 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready", rdy0, 1);
        @(negedge clk);
        in_valid = 1'b1;
        bin      = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accept", rdy0, 0);
        chk("ov_clr", ov0, 0);
    endtask

    // Called #1 after the accept edge plus `skip` further edges.
    task automatic finish_conv(input logic [15:0] v, input int skip);
        int          lat = 0;
        bit          held = 1'b1, busy = 1'b1;
        logic [19:0] e0, e1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ov0 === 1'b1) begin
                lat = skip + k;
                break;
            end
            if (bcd0 !== prev0 || bcd1 !== prev1) held = 1'b0;
            if (rdy0 !== 1'b0) busy = 1'b0;
        end
        e0 = ref_bcd(int'(v), 1'b0);
        e1 = ref_bcd(int'(v), 1'b1);
        chk("latency", lat, 16);
        chk("hold", held, 1);
        chk("busy", busy, 1);
        chk("bcd", bcd0, e0);
        chk("bcd_blank", bcd1, e1);
        chk("ov_blank", ov1, 1);
        chk("rdy_done", rdy0, 1);
        prev0 = e0;
        prev1 = e1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vals[4];
        logic [15:0] v;
        vals = '{16'd9, 16'd10, 16'd99, 16'd100};

        // Reset with in_valid high: must be ignored
        rst = 1'b1; in_valid = 1'b1; bin = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", rdy0, 1);
        chk("rst_ov", ov0, 0);
        chk("rst_bcd", bcd0, 20'h00000);
        chk("rst_bcd_blank", bcd1, 20'hFFFF0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        prev0 = 20'h00000;
        prev1 = 20'hFFFF0;

        // Directed values, both variants compared each time
        start(16'd0);     finish_conv(16'd0, 0);
        start(16'd65535); finish_conv(16'd65535, 0);
        start(16'd1234);  finish_conv(16'd1234, 0);
        start(16'd0);     finish_conv(16'd0, 0);
        start(16'd10000); finish_conv(16'd10000, 0);

        // Back-to-back with in_valid held, and disturbed during CONV
        @(negedge clk);
        in_valid = 1'b1; bin = vals[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("b2b_accept", rdy0, 0);
            chk("b2b_ov_clr", ov0, 0);
            if (i > 0) chk("b2b_spacing", cyc - acc_cyc, 17);
            acc_cyc = cyc;
            repeat (4) @(posedge clk);
            #1;
            in_valid = 1'b0; bin = 16'($urandom);
            repeat (3) @(posedge clk);
            #1;
            in_valid = 1'b1; bin = (i < 3) ? vals[i+1] : 16'($urandom);
            finish_conv(vals[i], 7);
        end
        in_valid = 1'b0;

        // Reset in the middle of a conversion
        start(16'd42);    finish_conv(16'd42, 0);
        start(16'd65535);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_bcd", bcd0, 20'h00000);
        chk("abort_bcd_blank", bcd1, 20'hFFFF0);
        chk("abort_ov", ov0, 0);
        chk("abort_rdy", rdy0, 1);
        in_valid = 1'b1; bin = 16'd42;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_hold_rdy", rdy0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_accept", rdy0, 0);
        prev0 = 20'h00000;
        prev1 = 20'hFFFF0;
        finish_conv(16'd42, 0);

        // Random sweep
        for (int n = 0; n < 300; n++) begin
            v = 16'($urandom_range(0, 65535));
            start(v);
            finish_conv(v, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
